// File: rtl/fk_sample_scheduler.sv
// Periodic sample sequencer for the forward-kinematics stage: snapshots the joint
// angles on every sample tick, launches one FK computation, captures the result
// with a sequence tag and recovers the FK stage through a watchdog when it stalls.
module fk_sample_scheduler #(
    parameter int PERIOD_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic signed [12:0] theta1_in,
    input  logic signed [12:0] theta2_in,
    output logic signed [12:0] fk_theta1,
    output logic signed [12:0] fk_theta2,
    output logic               fk_enable,
    output logic               fk_reset,
    input  logic        [13:0] fk_x,
    input  logic        [13:0] fk_y,
    input  logic               fk_data_ready,
    output logic        [13:0] x_out,
    output logic        [13:0] y_out,
    output logic               pos_valid,
    output logic         [7:0] pos_seq,
    output logic               busy,
    output logic         [7:0] overrun_cnt,
    output logic               timeout_err,
    input  logic               clear_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        LAUNCH,
        WAIT_RESULT,
        CAPTURE,
        RECOVER
    } state_t;

    localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RECOVER_LAST = 16'(RECOVER_CYCLES - 1);

    state_t      state;
    state_t      nextState;
    logic [15:0] periodCnt;
    logic [15:0] watchdog;
    logic [15:0] recoverCnt;
    logic        readyPrev;
    logic        tick;
    logic        readyRise;
    logic        inFlight;
    logic        enterLaunch;
    logic        enterCapture;
    logic        enterRecover;

    assign tick         = run && (periodCnt == PERIOD_LAST);
    assign readyRise    = fk_data_ready && !readyPrev;
    assign inFlight     = (state == LAUNCH) || (state == WAIT_RESULT) ||
                          (state == CAPTURE) || (state == RECOVER);
    assign enterLaunch  = (state == WAIT_TICK) && (nextState == LAUNCH);
    assign enterCapture = (state == WAIT_RESULT) && (nextState == CAPTURE);
    assign enterRecover = (state == WAIT_RESULT) && (nextState == RECOVER);

    // Free-running sample period counter, held at zero whenever scheduling is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            periodCnt <= '0;
        else if (!run)
            periodCnt <= '0;
        else if (periodCnt == PERIOD_LAST)
            periodCnt <= '0;
        else
            periodCnt <= periodCnt + 16'd1;
    end

    // Previous data-ready level so only a rising edge counts as a new result
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readyPrev <= 1'b0;
        else
            readyPrev <= fk_data_ready;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic plus the Moore strobes toward the FK stage
    always_comb begin
        nextState = state;
        fk_enable = 1'b0;
        fk_reset  = 1'b0;
        busy      = inFlight;
        case (state)
            IDLE:        if (run) nextState = WAIT_TICK;
            WAIT_TICK: begin
                if (!run)
                    nextState = IDLE;
                else if (tick)
                    nextState = LAUNCH;
            end
            LAUNCH: begin
                fk_enable = 1'b1;
                nextState = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (readyRise)
                    nextState = CAPTURE;
                else if (watchdog == TIMEOUT_LAST)
                    nextState = RECOVER;
            end
            CAPTURE:     nextState = run ? WAIT_TICK : IDLE;
            RECOVER: begin
                fk_reset = 1'b1;
                if (recoverCnt == RECOVER_LAST)
                    nextState = run ? WAIT_TICK : IDLE;
            end
            default:     nextState = IDLE;
        endcase
    end

    // Watchdog starts at zero in the launch cycle and runs until the result or expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            watchdog <= '0;
        else if (enterLaunch)
            watchdog <= '0;
        else if ((state == LAUNCH) || (state == WAIT_RESULT))
            watchdog <= watchdog + 16'd1;
    end

    // Counts how long the FK stage has been held in recovery reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            recoverCnt <= '0;
        else if (state != RECOVER)
            recoverCnt <= '0;
        else
            recoverCnt <= recoverCnt + 16'd1;
    end

    // Angle snapshot taken on the launching edge and held for the whole computation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fk_theta1 <= '0;
            fk_theta2 <= '0;
        end else if (enterLaunch) begin
            fk_theta1 <= theta1_in;
            fk_theta2 <= theta2_in;
        end
    end

    // Result capture: position, valid pulse and sequence tag appear together in CAPTURE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out     <= '0;
            y_out     <= '0;
            pos_valid <= 1'b0;
            pos_seq   <= '0;
        end else begin
            pos_valid <= enterCapture;
            if (enterCapture) begin
                x_out   <= fk_x;
                y_out   <= fk_y;
                pos_seq <= pos_seq + 8'd1;
            end
        end
    end

    // Error reporting; a new timeout or dropped tick takes priority over a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (enterRecover)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;

            if (tick && inFlight) begin
                if (overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end else if (clear_err) begin
                overrun_cnt <= '0;
            end
        end
    end

endmodule
